// File: rtl/buffer_senha_if.sv
// Keypad-to-password-stage bus: scanner key code and strobe in,
// digit buffer and status flags out to the display stage.
interface buffer_senha_if;
  logic [3:0]  num_sel;
  logic        salve;
  logic [15:0] digitos;
  logic [2:0]  qtd;
  logic        aberto;
  logic        erro;
  logic        bloqueado;

  modport master (
    output num_sel, salve,
    input  digitos, qtd, aberto, erro, bloqueado
  );

  modport slave (
    input  num_sel, salve,
    output digitos, qtd, aberto, erro, bloqueado
  );
endinterface

// File: rtl/buffer_senha.sv
// Password-entry stage: turns scanner strobes into one event per key press,
// collects up to four BCD digits, checks them on the confirm key and manages
// the open / error / lockout sequence with a shared 32-bit timer.
module buffer_senha #(
  parameter logic [15:0] SENHA    = 16'h1234,
  parameter int          MAX_TENT = 3,
  parameter int          T_MSG    = 50_000_000,
  parameter int          T_BLOQ   = 500_000_000
) (
  input  logic            clk,
  input  logic            rst,
  buffer_senha_if.slave   bus
);

  typedef enum logic [1:0] {
    ENTRADA   = 2'd0,
    ABERTO    = 2'd1,
    ERRO      = 2'd2,
    BLOQUEADO = 2'd3
  } state_t;

  localparam logic [2:0]  MAX_FAILS = 3'(MAX_TENT);
  localparam logic [31:0] MSG_LAST  = 32'(T_MSG - 1);
  localparam logic [31:0] BLOQ_LAST = 32'(T_BLOQ - 1);
  localparam logic [3:0]  KEY_CONF  = 4'd12;

  state_t      state_r, state_nx;
  logic        salve_d_r;
  logic [15:0] digitos_r, digitos_nx;
  logic [2:0]  qtd_r, qtd_nx;
  logic [2:0]  fails_r, fails_nx;
  logic [31:0] timer_r, timer_nx;
  logic        aberto_r, erro_r, bloqueado_r;

  logic        key_ev_s;
  logic        is_digit_s;
  logic        is_conf_s;
  logic [2:0]  fails_inc_s;

  // A press is the first cycle of a held strobe; the code is taken that cycle.
  assign key_ev_s    = bus.salve & ~salve_d_r;
  assign is_digit_s  = (bus.num_sel <= 4'd9);
  assign is_conf_s   = (bus.num_sel == KEY_CONF);
  assign fails_inc_s = fails_r + 3'd1;

  // Next-state, buffer, fail-count and timer decode for all four states.
  always_comb begin
    state_nx   = state_r;
    digitos_nx = digitos_r;
    qtd_nx     = qtd_r;
    fails_nx   = fails_r;
    timer_nx   = 32'd0;
    case (state_r)
      ENTRADA: begin
        if (key_ev_s && is_digit_s) begin
          if (qtd_r < 3'd4) begin
            digitos_nx = {digitos_r[11:0], bus.num_sel};
            qtd_nx     = qtd_r + 3'd1;
          end else begin
            qtd_nx = qtd_r;
          end
        end else if (key_ev_s && is_conf_s) begin
          if ((qtd_r == 3'd4) && (digitos_r == SENHA)) begin
            state_nx = ABERTO;
            fails_nx = 3'd0;
          end else begin
            fails_nx = fails_inc_s;
            if (fails_inc_s == MAX_FAILS) begin
              state_nx = BLOQUEADO;
            end else begin
              state_nx = ERRO;
            end
          end
        end else begin
          state_nx = state_r;
        end
      end
      ABERTO: begin
        if (key_ev_s && is_conf_s) begin
          state_nx   = ENTRADA;
          digitos_nx = 16'd0;
          qtd_nx     = 3'd0;
        end else begin
          state_nx = state_r;
        end
      end
      ERRO: begin
        if (timer_r == MSG_LAST) begin
          state_nx   = ENTRADA;
          digitos_nx = 16'd0;
          qtd_nx     = 3'd0;
        end else begin
          timer_nx = timer_r + 32'd1;
        end
      end
      BLOQUEADO: begin
        if (timer_r == BLOQ_LAST) begin
          state_nx   = ENTRADA;
          digitos_nx = 16'd0;
          qtd_nx     = 3'd0;
          fails_nx   = 3'd0;
        end else begin
          timer_nx = timer_r + 32'd1;
        end
      end
      default: begin
        state_nx   = ENTRADA;
        digitos_nx = 16'd0;
        qtd_nx     = 3'd0;
        fails_nx   = 3'd0;
      end
    endcase
  end

  // State, datapath and flag registers; flags follow the next state so they
  // switch on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ENTRADA;
      salve_d_r   <= 1'b1;
      digitos_r   <= 16'd0;
      qtd_r       <= 3'd0;
      fails_r     <= 3'd0;
      timer_r     <= 32'd0;
      aberto_r    <= 1'b0;
      erro_r      <= 1'b0;
      bloqueado_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      salve_d_r   <= bus.salve;
      digitos_r   <= digitos_nx;
      qtd_r       <= qtd_nx;
      fails_r     <= fails_nx;
      timer_r     <= timer_nx;
      aberto_r    <= (state_nx == ABERTO);
      erro_r      <= (state_nx == ERRO);
      bloqueado_r <= (state_nx == BLOQUEADO);
    end
  end

  assign bus.digitos   = digitos_r;
  assign bus.qtd       = qtd_r;
  assign bus.aberto    = aberto_r;
  assign bus.erro      = erro_r;
  assign bus.bloqueado = bloqueado_r;

endmodule

// File: tb/tb_buffer_senha.sv
// Bench for buffer_senha: a fixed key-press table with hand-computed results,
// a few multi-cycle corner sequences, and a randomized run, all cross-checked
// every cycle against a digit-queue / countdown reference model.
module tb_buffer_senha;

  localparam int T_MSG  = 4;
  localparam int T_BLOQ = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  buffer_senha_if bus ();

  buffer_senha #(
    .SENHA    (16'h1234),
    .MAX_TENT (3),
    .T_MSG    (T_MSG),
    .T_BLOQ   (T_BLOQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entered digits as a queue, failures as a count,
  // error / lockout as remaining-cycle countdowns.
  int q_m[$];
  int fails_m;
  bit open_m;
  int err_left;
  int lock_left;
  bit prev_s;

  typedef struct {
    logic [3:0]  code;
    int          hold;
    int          low;
    logic [15:0] dig;
    logic [2:0]  q;
    logic [2:0]  flags;  // {aberto, erro, bloqueado}
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_value();
    int v = 0;
    foreach (q_m[i]) v = v * 16 + q_m[i];
    return v;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [3:0] k);
    bit ev;
    ev = s && !prev_s;
    if (r) begin
      q_m.delete();
      fails_m = 0; open_m = 0; err_left = 0; lock_left = 0;
      prev_s = 1;
    end else begin
      if (err_left > 0) begin
        err_left--;
        if (err_left == 0) q_m.delete();
      end else if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) begin
          q_m.delete();
          fails_m = 0;
        end
      end else if (open_m) begin
        if (ev && k == 4'd12) begin
          open_m = 0;
          q_m.delete();
        end
      end else if (ev) begin
        if (k <= 4'd9) begin
          if (q_m.size() < 4) q_m.push_back(int'(k));
        end else if (k == 4'd12) begin
          if (q_m.size() == 4 && q_value() == 'h1234) begin
            open_m = 1;
            fails_m = 0;
          end else begin
            fails_m++;
            if (fails_m == 3) lock_left = T_BLOQ;
            else err_left = T_MSG;
          end
        end
      end
      prev_s = s;
    end
  endtask

  task automatic compare_model();
    check("m_digitos",   32'(bus.digitos),   32'(q_value()));
    check("m_qtd",       32'(bus.qtd),       32'(q_m.size()));
    check("m_aberto",    32'(bus.aberto),    32'(open_m));
    check("m_erro",      32'(bus.erro),      32'(err_left > 0));
    check("m_bloqueado", 32'(bus.bloqueado), 32'(lock_left > 0));
  endtask

  task automatic cycle(input logic r, input logic s, input logic [3:0] k);
    rst = r;
    bus.salve = s;
    bus.num_sel = k;
    @(posedge clk);
    model_step(r, s, k);
    #1;
    compare_model();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int low);
    for (int i = 0; i < hold; i++) cycle(1'b0, 1'b1, k);
    for (int i = 0; i < low; i++) cycle(1'b0, 1'b0, k);
  endtask

  task automatic check_const(input string tag, input logic [15:0] dig, input logic [2:0] q,
                             input logic [2:0] flags);
    check({tag, "_digitos"}, 32'(bus.digitos), 32'(dig));
    check({tag, "_qtd"},     32'(bus.qtd),     32'(q));
    check({tag, "_flags"},   32'({bus.aberto, bus.erro, bus.bloqueado}), 32'(flags));
  endtask

  initial begin
    logic s_r;
    logic [3:0] k_r;

    bus.salve = 1'b0;
    bus.num_sel = 4'd0;
    prev_s = 1;

    tbl[0]  = '{4'd1,  3, 2, 16'h0001, 3'd1, 3'b000};
    tbl[1]  = '{4'd2,  3, 2, 16'h0012, 3'd2, 3'b000};
    tbl[2]  = '{4'd3,  3, 2, 16'h0123, 3'd3, 3'b000};
    tbl[3]  = '{4'd4,  3, 2, 16'h1234, 3'd4, 3'b000};
    tbl[4]  = '{4'd5,  3, 2, 16'h1234, 3'd4, 3'b000};
    tbl[5]  = '{4'd12, 3, 2, 16'h1234, 3'd4, 3'b100};
    tbl[6]  = '{4'd7,  3, 2, 16'h1234, 3'd4, 3'b100};
    tbl[7]  = '{4'd12, 3, 2, 16'h0000, 3'd0, 3'b000};
    tbl[8]  = '{4'd10, 3, 2, 16'h0000, 3'd0, 3'b000};
    tbl[9]  = '{4'd1,  3, 2, 16'h0001, 3'd1, 3'b000};
    tbl[10] = '{4'd2,  3, 2, 16'h0012, 3'd2, 3'b000};
    tbl[11] = '{4'd12, 1, 1, 16'h0012, 3'd2, 3'b010};
    tbl[12] = '{4'd9,  1, 1, 16'h0012, 3'd2, 3'b010};
    tbl[13] = '{4'd3,  1, 2, 16'h0000, 3'd0, 3'b000};
    tbl[14] = '{4'd12, 3, 2, 16'h0000, 3'd0, 3'b000};
    tbl[15] = '{4'd12, 1, 1, 16'h0000, 3'd0, 3'b001};
    tbl[16] = '{4'd1,  3, 2, 16'h0000, 3'd0, 3'b001};
    tbl[17] = '{4'd2,  1, 1, 16'h0000, 3'd0, 3'b000};
    tbl[18] = '{4'd1,  3, 2, 16'h0001, 3'd1, 3'b000};
    tbl[19] = '{4'd2,  3, 2, 16'h0012, 3'd2, 3'b000};
    tbl[20] = '{4'd3,  3, 2, 16'h0123, 3'd3, 3'b000};
    tbl[21] = '{4'd4,  3, 2, 16'h1234, 3'd4, 3'b000};
    tbl[22] = '{4'd12, 3, 2, 16'h1234, 3'd4, 3'b100};
    tbl[23] = '{4'd12, 3, 2, 16'h0000, 3'd0, 3'b000};

    // Reset with a key held through release: no event may be recorded.
    cycle(1'b1, 1'b1, 4'd5);
    cycle(1'b1, 1'b1, 4'd5);
    check_const("reset", 16'h0000, 3'd0, 3'b000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'd5);
    check_const("held_thru_reset", 16'h0000, 3'd0, 3'b000);
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);

    // Key-press table: password, overflow, ignored codes, error, lockout.
    for (int i = 0; i < 24; i++) begin
      press(tbl[i].code, tbl[i].hold, tbl[i].low);
      check_const($sformatf("row%0d", i), tbl[i].dig, tbl[i].q, tbl[i].flags);
    end

    // Key held for 10 cycles from an empty buffer counts once.
    press(4'd7, 10, 2);
    check_const("held_key", 16'h0007, 3'd1, 3'b000);

    // Short confirm into ERRO, wait it out, then abort a second ERRO by reset.
    press(4'd12, 1, 4);
    check_const("short_conf_done", 16'h0000, 3'd0, 3'b000);
    press(4'd12, 1, 1);
    check_const("second_err", 16'h0000, 3'd0, 3'b010);
    cycle(1'b1, 1'b0, 4'd0);
    check_const("reset_mid_err", 16'h0000, 3'd0, 3'b000);

    // Randomized run checked every cycle against the model.
    s_r = 1'b0;
    k_r = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        press(4'd1, 1, 1); press(4'd2, 1, 1); press(4'd3, 1, 1);
        press(4'd4, 1, 1); press(4'd12, 1, 1);
        s_r = 1'b0;
      end
      if (s_r) begin
        if ($urandom_range(0, 2) == 0) s_r = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        s_r = 1'b1;
        if ($urandom_range(0, 1) == 0) k_r = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 3) == 0) k_r = 4'd12;
        else k_r = 4'($urandom_range(1, 4));
      end
      cycle(($urandom_range(0, 299) == 0), s_r, k_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
